// File: rtl/ep_alu_pkg.sv
// Shared constants for the FrontPanel arithmetic bank: op codes, FSM states, status layout.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ep_alu_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_ACC = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_EXEC  = 2'd2,
        S_WRITE = 2'd3
    } state_e;

    // status = {err, busy, 6'b0, ovf[7:0], 8'b0, pend[7:0]}
    localparam int ST_PEND_LSB = 0;
    localparam int ST_OVF_LSB  = 16;
    localparam int ST_BUSY_BIT = 30;
    localparam int ST_ERR_BIT  = 31;

endpackage

// File: rtl/ep_alu_rr_arb.sv
// Round-robin arbiter: picks the lowest-index request at or after ptr, wrapping at NCH.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller only samples the grant when it can accept one.
// Ports: req_i requests, ptr_i search start; gnt_o one-hot grant, idx_o its index, vld_o any grant.
module ep_alu_rr_arb #(
    parameter int NCH = 4,
    parameter int IW  = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic [NCH-1:0] req_i,
    input  logic [IW-1:0]  ptr_i,
    output logic [NCH-1:0] gnt_o,
    output logic [IW-1:0]  idx_o,
    output logic           vld_o
);

    int          c;
    logic [IW-1:0] cidx;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        vld_o = 1'b0;
        c     = 0;
        cidx  = '0;
        for (int k = 0; k < NCH; k++) begin
            c    = (int'(ptr_i) + k) % NCH;
            cidx = IW'(c);
            if (!vld_o && req_i[cidx]) begin
                vld_o       = 1'b1;
                idx_o       = cidx;
                gnt_o[cidx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ep_alu_bank.sv
// Multi-channel ALU bank: one shared engine serves pending channels round-robin (ADD/SUB/MUL/ACC).
// Latency: start -> done in 4 cycles for ADD/SUB/ACC, 3+W cycles for MUL, with the engine idle.
// Backpressure: none; a start to a channel that is already pending or active is dropped and flags err.
// Ports: okClk, rst_n (sync, active-low); op_a/op_b/op_sel/start/clr per channel in;
//        result (Wire Out), done (TriggerOut), status word, led (open-drain, active low) out.
// Option: define EP_ALU_SAT_EN to clamp overflowing results instead of wrapping.
module ep_alu_bank
    import ep_alu_pkg::*;
#(
    parameter int NCH = 4,
    parameter int W   = 32
) (
    input  logic             okClk,
    input  logic             rst_n,
    input  logic [NCH*W-1:0] op_a,
    input  logic [NCH*W-1:0] op_b,
    input  logic [NCH*2-1:0] op_sel,
    input  logic [NCH-1:0]   start,
    input  logic [NCH-1:0]   clr,
    output logic [NCH*W-1:0] result,
    output logic [NCH-1:0]   done,
    output logic [31:0]      status,
    output wire  [3:0]       led
);

    localparam int IW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int CW = $clog2(W);

    logic [NCH-1:0][W-1:0] a_arr, b_arr;
    logic [NCH-1:0][1:0]   sel_arr;
    assign a_arr   = op_a;
    assign b_arr   = op_b;
    assign sel_arr = op_sel;

    state_e                state_q;
    logic [IW-1:0]         ptr_q, g_q;
    logic [NCH-1:0]        g_oh_q;
    logic [NCH-1:0]        pend_q, pend_d, ovf_q, done_q, active;
    logic                  err_q, busy_q, err_hit;
    logic [NCH-1:0][W-1:0] res_q;
    logic [W-1:0]          a_q, b_q, r_q;
    logic [1:0]            op_q;
    logic [CW-1:0]         cnt_q;
    logic [2*W-1:0]        mac_q, mul_nxt;

    logic [NCH-1:0] arb_gnt;
    logic [IW-1:0]  arb_idx;
    logic           arb_vld;

    ep_alu_rr_arb #(.NCH(NCH), .IW(IW)) u_arb (
        .req_i (pend_q),
        .ptr_i (ptr_q),
        .gnt_o (arb_gnt),
        .idx_o (arb_idx),
        .vld_o (arb_vld)
    );

    // The granted channel stays "active" from grant until the engine returns to IDLE.
    assign active  = (state_q != S_IDLE) ? g_oh_q : '0;
    assign err_hit = |(start & (pend_q | active));

    always_comb begin
        pend_d = pend_q | (start & ~pend_q & ~active);
        if (state_q == S_LOAD) pend_d = pend_d & ~g_oh_q;
    end

    // MSB-first shift-add: cnt_q indexes the multiplier bit consumed this cycle.
    assign mul_nxt = (mac_q << 1) + ({(2*W){b_q[cnt_q]}} & {{W{1'b0}}, a_q});

    logic [W:0]   sum, diff, accs;
    logic [W-1:0] res_w, res_fin;
    logic         ovf_w;

    always_comb begin
        sum   = {1'b0, a_q} + {1'b0, b_q};
        diff  = {1'b0, a_q} - {1'b0, b_q};
        accs  = {1'b0, r_q} + {1'b0, a_q};
        res_w = '0;
        ovf_w = 1'b0;
        case (op_q)
            OP_ADD:  begin res_w = sum[W-1:0];      ovf_w = sum[W];             end
            OP_SUB:  begin res_w = diff[W-1:0];     ovf_w = diff[W];            end
            OP_MUL:  begin res_w = mul_nxt[W-1:0];  ovf_w = |mul_nxt[2*W-1:W];  end
            default: begin res_w = accs[W-1:0];     ovf_w = accs[W];            end
        endcase
`ifdef EP_ALU_SAT_EN
        // Borrow floors at zero; every other overflow pins to all-ones.
        if (ovf_w) res_fin = (op_q == OP_SUB) ? '0 : '1;
        else       res_fin = res_w;
`else
        res_fin = res_w;
`endif
    end

    always_ff @(posedge okClk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            g_q     <= '0;
            g_oh_q  <= '0;
            pend_q  <= '0;
            ovf_q   <= '0;
            done_q  <= '0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
            res_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            r_q     <= '0;
            op_q    <= OP_ADD;
            cnt_q   <= '0;
            mac_q   <= '0;
        end else begin
            done_q <= '0;
            pend_q <= pend_d;
            err_q  <= err_q | err_hit;
            case (state_q)
                S_IDLE: begin
                    if (arb_vld) begin
                        g_q     <= arb_idx;
                        g_oh_q  <= arb_gnt;
                        busy_q  <= 1'b1;
                        state_q <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    a_q     <= a_arr[g_q];
                    b_q     <= b_arr[g_q];
                    op_q    <= sel_arr[g_q];
                    r_q     <= res_q[g_q];
                    cnt_q   <= CW'(W - 1);
                    mac_q   <= '0;
                    state_q <= S_EXEC;
                end
                S_EXEC: begin
                    if (op_q == OP_MUL && cnt_q != '0) begin
                        mac_q <= mul_nxt;
                        cnt_q <= cnt_q - CW'(1);
                    end else begin
                        res_q[g_q] <= res_fin;
                        done_q     <= g_oh_q;
                        if (ovf_w) ovf_q[g_q] <= 1'b1;
                        state_q    <= S_WRITE;
                    end
                end
                default: begin
                    ptr_q   <= (g_q == IW'(NCH - 1)) ? '0 : g_q + IW'(1);
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
            // Placed last so a clear beats a same-cycle result write.
            for (int i = 0; i < NCH; i++) begin
                if (clr[i]) begin
                    res_q[i] <= '0;
                    ovf_q[i] <= 1'b0;
                end
            end
        end
    end

    assign result = res_q;
    assign done   = done_q;

    always_comb begin
        status                         = '0;
        status[ST_ERR_BIT]             = err_q;
        status[ST_BUSY_BIT]            = busy_q;
        status[ST_OVF_LSB  +: NCH]     = ovf_q;
        status[ST_PEND_LSB +: NCH]     = pend_q;
    end

    assign led[0] = busy_q    ? 1'b0 : 1'bz;
    assign led[1] = (|ovf_q)  ? 1'b0 : 1'bz;
    assign led[2] = err_q     ? 1'b0 : 1'bz;
    assign led[3] = (|pend_q) ? 1'b0 : 1'bz;

endmodule

// File: tb/tb_ep_alu_bank.sv
// Directed bench for ep_alu_bank (NCH=4, W=32): latency, arithmetic, overflow, clear, round-robin, err, reset.
// Latency: n/a.
// Backpressure: n/a.
module tb_ep_alu_bank;

    localparam int NCH = 4;
    localparam int W   = 32;

    logic             okClk = 1'b0;
    logic             rst_n;
    logic [NCH*W-1:0] op_a, op_b;
    logic [NCH*2-1:0] op_sel;
    logic [NCH-1:0]   start, clr;
    logic [NCH*W-1:0] result;
    logic [NCH-1:0]   done;
    logic [31:0]      status;
    tri1  [3:0]       led;

    int n_pass = 0;
    int n_chk  = 0;

    ep_alu_bank #(.NCH(NCH), .W(W)) dut (
        .okClk  (okClk),
        .rst_n  (rst_n),
        .op_a   (op_a),
        .op_b   (op_b),
        .op_sel (op_sel),
        .start  (start),
        .clr    (clr),
        .result (result),
        .done   (done),
        .status (status),
        .led    (led)
    );

    always #5 okClk = ~okClk;

    task automatic tick();
        @(posedge okClk);
        #1;
    endtask

    task automatic settle();
        tick();
        tick();
    endtask

    task automatic set_ch(input int ch, input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] op);
        op_a[ch*W +: W]   = a;
        op_b[ch*W +: W]   = b;
        op_sel[ch*2 +: 2] = op;
    endtask

    // Leaves the bench in cycle 1 (start was high in cycle 0).
    task automatic pulse_start(input logic [NCH-1:0] m);
        start = m;
        tick();
        start = '0;
    endtask

    task automatic pulse_clr(input logic [NCH-1:0] m);
        clr = m;
        tick();
        clr = '0;
    endtask

    // Call in cycle 1; returns the cycle in which done[ch] is seen (200 on timeout).
    task automatic wait_done(input int ch, output int cyc);
        cyc = 1;
        while (done[ch] !== 1'b1 && cyc < 200) begin
            tick();
            cyc++;
        end
    endtask

    function automatic logic [W-1:0] res(input int ch);
        return result[ch*W +: W];
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        tick(); tick(); tick();
        n_chk++; if (result !== '0) $display("FAIL reset_result: got %h want 0", result); else n_pass++;
        n_chk++; if (done !== '0) $display("FAIL reset_done: got %b want 0", done); else n_pass++;
        n_chk++; if (status !== 32'h0) $display("FAIL reset_status: got %h want 0", status); else n_pass++;
        n_chk++; if (led !== 4'b1111) $display("FAIL reset_led: got %b want 1111 (released)", led); else n_pass++;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_add();
        int c;
        set_ch(0, 32'd5, 32'd7, 2'b00);
        pulse_start(4'b0001);
        wait_done(0, c);
        n_chk++; if (c !== 4) $display("FAIL add_latency: got %0d want 4", c); else n_pass++;
        n_chk++; if (res(0) !== 32'd12) $display("FAIL add_result: got %0d want 12", res(0)); else n_pass++;
        n_chk++; if (status[16] !== 1'b0) $display("FAIL add_ovf: got %b want 0", status[16]); else n_pass++;
        settle();
    endtask

    task automatic test_add_ovf();
        int c;
        logic [W-1:0] exp;
`ifdef EP_ALU_SAT_EN
        exp = 32'hFFFF_FFFF;
`else
        exp = 32'h0;
`endif
        set_ch(1, 32'hFFFF_FFFF, 32'd1, 2'b00);
        pulse_start(4'b0010);
        wait_done(1, c);
        n_chk++; if (res(1) !== exp) $display("FAIL addovf_result: got %h want %h", res(1), exp); else n_pass++;
        n_chk++; if (status[17] !== 1'b1) $display("FAIL addovf_flag: got %b want 1", status[17]); else n_pass++;
        settle();
        n_chk++; if (led[1] !== 1'b0) $display("FAIL addovf_led: got %b want 0", led[1]); else n_pass++;
        pulse_clr(4'b0010);
        n_chk++; if (res(1) !== 32'h0) $display("FAIL clr_result: got %h want 0", res(1)); else n_pass++;
        n_chk++; if (status[17] !== 1'b0) $display("FAIL clr_ovf: got %b want 0", status[17]); else n_pass++;
    endtask

    task automatic test_sub();
        int c;
        logic [W-1:0] exp;
`ifdef EP_ALU_SAT_EN
        exp = 32'h0;
`else
        exp = 32'hFFFF_FFFE;
`endif
        set_ch(3, 32'd3, 32'd5, 2'b01);
        pulse_start(4'b1000);
        wait_done(3, c);
        n_chk++; if (res(3) !== exp) $display("FAIL sub_result: got %h want %h", res(3), exp); else n_pass++;
        n_chk++; if (status[19] !== 1'b1) $display("FAIL sub_borrow: got %b want 1", status[19]); else n_pass++;
        settle();
        pulse_clr(4'b1000);
    endtask

    task automatic test_mul();
        int c;
        logic [W-1:0] exp;
`ifdef EP_ALU_SAT_EN
        exp = 32'hFFFF_FFFF;
`else
        exp = 32'h0;
`endif
        set_ch(2, 32'h1_0000, 32'h1_0000, 2'b10);
        pulse_start(4'b0100);
        wait_done(2, c);
        n_chk++; if (c !== 35) $display("FAIL mul_latency: got %0d want 35", c); else n_pass++;
        n_chk++; if (res(2) !== exp) $display("FAIL mul_ovf_result: got %h want %h", res(2), exp); else n_pass++;
        n_chk++; if (status[18] !== 1'b1) $display("FAIL mul_ovf_flag: got %b want 1", status[18]); else n_pass++;
        settle();
        pulse_clr(4'b0100);
        set_ch(2, 32'd300, 32'd7, 2'b10);
        pulse_start(4'b0100);
        wait_done(2, c);
        n_chk++; if (res(2) !== 32'd2100) $display("FAIL mul_result: got %0d want 2100", res(2)); else n_pass++;
        n_chk++; if (status[18] !== 1'b0) $display("FAIL mul_no_ovf: got %b want 0", status[18]); else n_pass++;
        settle();
    endtask

    task automatic test_clr_vs_write();
        set_ch(3, 32'd10, 32'd20, 2'b00);
        pulse_start(4'b1000);
        tick(); tick();
        clr = 4'b1000;
        tick();
        clr = '0;
        n_chk++; if (done[3] !== 1'b1) $display("FAIL clrwrite_done: got %b want 1", done[3]); else n_pass++;
        n_chk++; if (res(3) !== 32'h0) $display("FAIL clrwrite_result: got %h want 0", res(3)); else n_pass++;
        settle();
    endtask

    // Starts all channels at once and checks grant order, 4-cycle spacing and results.
    task automatic run_all(input string tag, input int f0, input int f1, input int f2, input int f3);
        int ord[4];
        int tm[4];
        int exp_ord[4];
        int n;
        exp_ord[0] = f0; exp_ord[1] = f1; exp_ord[2] = f2; exp_ord[3] = f3;
        for (int i = 0; i < NCH; i++) set_ch(i, 32'(i + 1), 32'd100, 2'b00);
        pulse_clr(4'b1111);
        pulse_start(4'b1111);
        n = 0;
        for (int cyc = 1; cyc < 40; cyc++) begin
            for (int i = 0; i < NCH; i++) begin
                if (done[i] === 1'b1 && n < 4) begin
                    ord[n] = i;
                    tm[n]  = cyc;
                    n++;
                end
            end
            tick();
        end
        n_chk++; if (n !== 4) $display("FAIL %s_count: got %0d want 4", tag, n); else n_pass++;
        for (int k = 0; k < n; k++) begin
            n_chk++;
            if (ord[k] !== exp_ord[k] || tm[k] !== 4 + 4 * k)
                $display("FAIL %s_slot%0d: got ch%0d at cyc %0d want ch%0d at cyc %0d",
                         tag, k, ord[k], tm[k], exp_ord[k], 4 + 4 * k);
            else n_pass++;
        end
        for (int i = 0; i < NCH; i++) begin
            n_chk++;
            if (res(i) !== 32'(i + 101)) $display("FAIL %s_res%0d: got %0d want %0d", tag, i, res(i), i + 101);
            else n_pass++;
        end
    endtask

    task automatic test_round_robin();
        int c;
        run_all("rr0", 0, 1, 2, 3);
        // A lone grant to ch1 moves the pointer to ch2.
        set_ch(1, 32'd1, 32'd1, 2'b00);
        pulse_start(4'b0010);
        wait_done(1, c);
        settle();
        run_all("rr2", 2, 3, 0, 1);
    endtask

    task automatic test_err_acc();
        int c;
        int nd;
        pulse_clr(4'b0001);
        set_ch(0, 32'd3, 32'd0, 2'b11);
        pulse_start(4'b0001);
        tick();
        pulse_start(4'b0001);
        nd = 0;
        for (int k = 0; k < 12; k++) begin
            if (done[0] === 1'b1) nd++;
            tick();
        end
        n_chk++; if (nd !== 1) $display("FAIL err_dup_done: got %0d want 1", nd); else n_pass++;
        n_chk++; if (status[31] !== 1'b1) $display("FAIL err_flag: got %b want 1", status[31]); else n_pass++;
        n_chk++; if (led[2] !== 1'b0) $display("FAIL err_led: got %b want 0", led[2]); else n_pass++;
        for (int r = 0; r < 2; r++) begin
            pulse_start(4'b0001);
            wait_done(0, c);
            settle();
        end
        n_chk++; if (res(0) !== 32'd9) $display("FAIL acc_result: got %0d want 9", res(0)); else n_pass++;
    endtask

    task automatic test_reset_mid_mul();
        int c;
        int nd;
        set_ch(2, 32'd3, 32'd5, 2'b10);
        pulse_start(4'b0100);
        for (int k = 0; k < 6; k++) tick();
        rst_n = 1'b0;
        tick();
        n_chk++; if (status !== 32'h0) $display("FAIL rstmul_status: got %h want 0", status); else n_pass++;
        n_chk++; if (done !== '0) $display("FAIL rstmul_done: got %b want 0", done); else n_pass++;
        rst_n = 1'b1;
        tick();
        n_chk++; if (led !== 4'b1111) $display("FAIL rstmul_led: got %b want 1111 (released)", led); else n_pass++;
        nd = 0;
        for (int k = 0; k < 45; k++) begin
            if (done !== '0) nd++;
            tick();
        end
        n_chk++; if (nd !== 0) $display("FAIL rstmul_stray_done: got %0d want 0", nd); else n_pass++;
        n_chk++; if (res(2) !== 32'h0) $display("FAIL rstmul_result: got %h want 0", res(2)); else n_pass++;
        set_ch(0, 32'd1, 32'd1, 2'b00);
        pulse_start(4'b0001);
        wait_done(0, c);
        n_chk++; if (c !== 4 || res(0) !== 32'd2)
            $display("FAIL rstmul_recover: got cyc %0d res %0d want cyc 4 res 2", c, res(0));
        else n_pass++;
    endtask

    initial begin
        rst_n  = 1'b0;
        op_a   = '0;
        op_b   = '0;
        op_sel = '0;
        start  = '0;
        clr    = '0;
        test_reset();
        test_add();
        test_add_ovf();
        test_sub();
        test_mul();
        test_clr_vs_write();
        test_round_robin();
        test_err_acc();
        test_reset_mid_mul();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
